// File: rtl/dphy_pkg.sv
// Shared D-PHY transmit definitions: FSM states, LP line encodings and the HS sync byte.
// The ULPS states exist only when DPHY_ULPS_EN is defined.
package dphy_pkg;

   localparam logic [1:0] LP11 = 2'b11;
   localparam logic [1:0] LP01 = 2'b01;
   localparam logic [1:0] LP10 = 2'b10;
   localparam logic [1:0] LP00 = 2'b00;

   localparam logic [7:0] SYNC_BYTE = 8'hB8;

   typedef enum logic [3:0] {
      ST_STOP,
      ST_HS_RQST,
      ST_PREPARE,
      ST_HS_ZERO,
      ST_SYNC,
      ST_HS,
      ST_TRAIL,
      ST_EXIT
`ifdef DPHY_ULPS_EN
      ,
      ST_ULPS_RQST,
      ST_ULPS,
      ST_ULPS_EXIT
`endif
   } dphy_state_e;

   // What each lane loads into its HS byte register on the next edge.
   typedef enum logic [1:0] {
      BSEL_ZERO,
      BSEL_SYNC,
      BSEL_DATA,
      BSEL_TRAIL
   } byte_sel_e;

   function automatic int max_cyc(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/dphy_lane_tx.sv
// One HS data lane: registered output byte, last-transmitted-bit tracker and trail fill.
module dphy_lane_tx
   import dphy_pkg::*;
(
   input  logic       byteclk,
   input  logic       reset,
   input  byte_sel_e  byte_sel,
   input  logic       accept,
   input  logic       valid,
   input  logic [7:0] data,
   output logic [7:0] hs_byte
);

   logic       last_bit_reg;
   logic       last_bit_next;
   logic [7:0] hs_byte_reg;
   logic [7:0] hs_byte_next;
   logic       take;

   assign take = accept & valid;

   // The trail level is the inverse of the final bit on the wire, so the
   // tracker must already reflect the byte loaded on the same edge.
   always_comb begin
      last_bit_next = last_bit_reg;
      if (byte_sel == BSEL_SYNC)
         last_bit_next = SYNC_BYTE[7];
      else if (take)
         last_bit_next = data[7];

      hs_byte_next = 8'h00;
      case (byte_sel)
         BSEL_SYNC:  hs_byte_next = SYNC_BYTE;
         BSEL_DATA:  hs_byte_next = take ? data : 8'h00;
         BSEL_TRAIL: hs_byte_next = {8{~last_bit_next}};
         default:    hs_byte_next = 8'h00;
      endcase
   end

   always_ff @(posedge byteclk or posedge reset) begin
      if (reset) begin
         last_bit_reg <= 1'b0;
         hs_byte_reg  <= 8'h00;
      end else begin
         last_bit_reg <= last_bit_next;
         hs_byte_reg  <= hs_byte_next;
      end
   end

   assign hs_byte = hs_byte_reg;

endmodule

// File: rtl/dphy_tx_lanes.sv
// D-PHY multi-lane transmitter: shared LP/HS sequencing FSM driving NUM_LANES lane datapaths.
// Define DPHY_ULPS_EN to add the ultra-low-power entry/exit states.
module dphy_tx_lanes
   import dphy_pkg::*;
#(
   parameter int NUM_LANES   = 2,
   parameter int PREPARE_CYC = 2,
   parameter int ZERO_CYC    = 4,
   parameter int TRAIL_CYC   = 2,
   parameter int EXIT_CYC    = 4
) (
   input  logic                   byteclk,
   input  logic                   reset,
   input  logic                   txrequest_hs,
   input  logic [8*NUM_LANES-1:0] txdata,
   input  logic [NUM_LANES-1:0]   txvalid,
   input  logic                   ulps_req,
   output logic                   txready_hs,
   output logic                   stopstate,
   output logic [2*NUM_LANES-1:0] lane_lp,
   output logic [8*NUM_LANES-1:0] hs_byte,
   output logic                   hs_en,
   output logic                   hs_clk_active,
   output logic                   ulps_active
);

   localparam int MAX_CYC = max_cyc(PREPARE_CYC, ZERO_CYC, TRAIL_CYC, EXIT_CYC);
   localparam int CW      = $clog2(MAX_CYC) + 1;

   dphy_state_e state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          cnt_done;

   logic [1:0] lp_reg, lp_next;
   logic       stop_reg, stop_next;
   logic       hs_en_reg, hs_en_next;
   logic       ready_reg, ready_next;
   logic       clk_act_reg, clk_act_next;
   logic       ulps_reg, ulps_next;
   byte_sel_e  byte_sel_next;
   logic       accept;

   assign cnt_done = (cnt_reg == '0);
   // A cycle that ends the burst carries no data, so a dropped request gates acceptance.
   assign accept   = ready_reg & txrequest_hs;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         ST_STOP: begin
            if (txrequest_hs)
               state_next = ST_HS_RQST;
`ifdef DPHY_ULPS_EN
            else if (ulps_req)
               state_next = ST_ULPS_RQST;
`endif
         end
         ST_HS_RQST: begin
            state_next = ST_PREPARE;
            cnt_next   = CW'(PREPARE_CYC - 1);
         end
         ST_PREPARE: begin
            if (cnt_done) begin
               state_next = ST_HS_ZERO;
               cnt_next   = CW'(ZERO_CYC - 1);
            end else
               cnt_next = cnt_reg - 1'b1;
         end
         ST_HS_ZERO: begin
            if (cnt_done)
               state_next = ST_SYNC;
            else
               cnt_next = cnt_reg - 1'b1;
         end
         ST_SYNC: begin
            if (txrequest_hs)
               state_next = ST_HS;
            else begin
               state_next = ST_TRAIL;
               cnt_next   = CW'(TRAIL_CYC - 1);
            end
         end
         ST_HS: begin
            if (!txrequest_hs) begin
               state_next = ST_TRAIL;
               cnt_next   = CW'(TRAIL_CYC - 1);
            end
         end
         ST_TRAIL: begin
            if (cnt_done) begin
               state_next = ST_EXIT;
               cnt_next   = CW'(EXIT_CYC - 1);
            end else
               cnt_next = cnt_reg - 1'b1;
         end
         ST_EXIT: begin
            if (cnt_done)
               state_next = ST_STOP;
            else
               cnt_next = cnt_reg - 1'b1;
         end
`ifdef DPHY_ULPS_EN
         ST_ULPS_RQST: state_next = ST_ULPS;
         ST_ULPS: begin
            if (!ulps_req) begin
               state_next = ST_ULPS_EXIT;
               cnt_next   = CW'(EXIT_CYC - 1);
            end
         end
         ST_ULPS_EXIT: begin
            if (cnt_done)
               state_next = ST_STOP;
            else
               cnt_next = cnt_reg - 1'b1;
         end
`endif
         default: state_next = ST_STOP;
      endcase
   end

   // Outputs are decoded from the next state so their registers line up with state_reg.
   always_comb begin
      lp_next       = LP00;
      stop_next     = 1'b0;
      hs_en_next    = 1'b0;
      ready_next    = 1'b0;
      clk_act_next  = 1'b0;
      ulps_next     = 1'b0;
      byte_sel_next = BSEL_ZERO;
      case (state_next)
         ST_STOP: begin
            lp_next   = LP11;
            stop_next = 1'b1;
         end
         ST_HS_RQST: lp_next = LP01;
         ST_PREPARE: lp_next = LP00;
         ST_HS_ZERO: begin
            hs_en_next   = 1'b1;
            clk_act_next = 1'b1;
         end
         ST_SYNC: begin
            hs_en_next    = 1'b1;
            clk_act_next  = 1'b1;
            byte_sel_next = BSEL_SYNC;
         end
         ST_HS: begin
            hs_en_next    = 1'b1;
            clk_act_next  = 1'b1;
            ready_next    = 1'b1;
            byte_sel_next = BSEL_DATA;
         end
         ST_TRAIL: begin
            hs_en_next    = 1'b1;
            clk_act_next  = 1'b1;
            byte_sel_next = BSEL_TRAIL;
         end
         ST_EXIT: lp_next = LP11;
`ifdef DPHY_ULPS_EN
         ST_ULPS_RQST: lp_next = LP10;
         ST_ULPS: begin
            lp_next   = LP00;
            ulps_next = 1'b1;
         end
         ST_ULPS_EXIT: lp_next = LP10;
`endif
         default: begin
            lp_next   = LP11;
            stop_next = 1'b1;
         end
      endcase
   end

   always_ff @(posedge byteclk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_STOP;
         cnt_reg     <= '0;
         lp_reg      <= LP11;
         stop_reg    <= 1'b1;
         hs_en_reg   <= 1'b0;
         ready_reg   <= 1'b0;
         clk_act_reg <= 1'b0;
         ulps_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         lp_reg      <= lp_next;
         stop_reg    <= stop_next;
         hs_en_reg   <= hs_en_next;
         ready_reg   <= ready_next;
         clk_act_reg <= clk_act_next;
         ulps_reg    <= ulps_next;
      end
   end

`ifndef DPHY_ULPS_EN
   logic ulps_req_unused;
   assign ulps_req_unused = ulps_req;
`endif

   assign txready_hs    = ready_reg;
   assign stopstate     = stop_reg;
   assign hs_en         = hs_en_reg;
   assign hs_clk_active = clk_act_reg;
   assign ulps_active   = ulps_reg;

   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign lane_lp[2*gi +: 2] = lp_reg;

      dphy_lane_tx u_lane (
         .byteclk  (byteclk),
         .reset    (reset),
         .byte_sel (byte_sel_next),
         .accept   (accept),
         .valid    (txvalid[gi]),
         .data     (txdata[8*gi +: 8]),
         .hs_byte  (hs_byte[8*gi +: 8])
      );
   end

endmodule

// File: doc/dphy_tx_lanes.md
DPHY_TX_LANES -- requirements
Module: dphy_tx_lanes

Interface
REQ-001 SHALL have parameter NUM_LANES, default 2, number of data lanes (legal 1..4).
REQ-002 SHALL have parameter PREPARE_CYC, default 2, LP-00 HS-PREPARE length in byteclk cycles (>=1).
REQ-003 SHALL have parameter ZERO_CYC, default 4, HS-ZERO length in cycles (>=1).
REQ-004 SHALL have parameters TRAIL_CYC, default 2, and EXIT_CYC, default 4, HS-TRAIL and HS-EXIT lengths in cycles (>=1).
REQ-005 SHALL have ports: byteclk in 1 byte clock; reset in 1 asynchronous active-high reset.
REQ-006 SHALL have ports: txrequest_hs in 1 HS burst request; txdata in 8*NUM_LANES lane bytes (lane i = bits 8i+7:8i); txvalid in NUM_LANES per-lane byte valid.
REQ-007 SHALL have ports: ulps_req in 1 ULPS request; txready_hs out 1 data accept; stopstate out 1 lanes in LP-11 idle.
REQ-008 SHALL have ports: lane_lp out 2*NUM_LANES {Dp,Dn} LP levels per lane; hs_byte out 8*NUM_LANES HS byte per lane; hs_en out 1 HS drivers on; hs_clk_active out 1 HS clock gate; ulps_active out 1 in ULPS.

Function
REQ-009 SHALL implement one FSM shared by all lanes: STOP, HS_RQST, PREPARE, HS_ZERO, SYNC, HS, TRAIL, EXIT, ULPS_RQST, ULPS, ULPS_EXIT; all outputs registered.
REQ-010 STOP: lane_lp=2'b11, stopstate=1; txrequest_hs -> HS_RQST; else ulps_req -> ULPS_RQST; both high -> HS_RQST.
REQ-011 HS_RQST: lane_lp=2'b01 for 1 cycle -> PREPARE.
REQ-012 PREPARE: lane_lp=2'b00, hs_en=0, PREPARE_CYC cycles -> HS_ZERO.
REQ-013 HS_ZERO: hs_en=1, hs_byte=8'h00 all lanes, ZERO_CYC cycles -> SYNC.
REQ-014 SYNC: hs_byte=8'hB8 all lanes, 1 cycle; -> HS if txrequest_hs, else -> TRAIL.
REQ-015 HS: txready_hs=1; byte on lane i accepted when txready_hs && txvalid[i], appears on hs_byte lane i next cycle; lane with txvalid=0 drives 8'h00 and keeps its last-bit register unchanged.
REQ-016 HS -> TRAIL when txrequest_hs low; txready_hs low from the first TRAIL cycle; no byte accepted in that cycle.
REQ-017 TRAIL: hs_byte lane i = {8{~last bit sent on lane i}} (bit 7 of last HS byte, or of 8'hB8 if none), TRAIL_CYC cycles -> EXIT.
REQ-018 EXIT: hs_en=0, lane_lp=2'b11, EXIT_CYC cycles -> STOP; txrequest_hs during TRAIL/EXIT ignored until STOP.
REQ-019 txrequest_hs dropped during HS_RQST/PREPARE/HS_ZERO SHALL NOT abort; sequence completes via SYNC -> TRAIL.
REQ-020 hs_clk_active SHALL be 1 in HS_ZERO, SYNC, HS, TRAIL; else 0.
REQ-021 Cycle counter SHALL be single, width $clog2(max CYC)+1, loaded on state entry, no wrap.
REQ-022 hs_byte SHALL be 8'h00 whenever hs_en=0.

Reset
REQ-023 reset SHALL force STOP asynchronously: lane_lp all 2'b11, stopstate=1, hs_byte=0, hs_en=0, txready_hs=0, hs_clk_active=0, ulps_active=0, counter=0, last-bit registers=0.
REQ-024 reset mid-burst SHALL abandon the burst with no TRAIL; first post-reset cycle is STOP.

Configuration
REQ-025 With DPHY_ULPS_EN defined: ULPS_RQST lane_lp=2'b10 1 cycle -> ULPS; ULPS lane_lp=2'b00, ulps_active=1 while ulps_req; ulps_req low -> ULPS_EXIT lane_lp=2'b10 for EXIT_CYC cycles -> STOP.
REQ-026 Without DPHY_ULPS_EN: ulps_req port present but ignored, ulps_active tied 0, ULPS states absent.

Structure
REQ-027 FSM state enum, LP encodings (LP11/LP01/LP10/LP00) and SYNC_BYTE=8'hB8 SHALL live in shared package dphy_pkg.
REQ-028 Per-lane datapath (hs_byte register, last-bit register, trail fill) SHALL be sub-module dphy_lane_tx, instantiated NUM_LANES times via generate.

Verification (NUM_LANES=2, defaults)
REQ-029 txrequest_hs high from STOP -> lane_lp 11,01(1),00(2); hs_byte 00 x4, B8 x1; txready_hs high after 8 pre-HS cycles.
REQ-030 HS, lane0 bytes 8'h12,8'h34 valid, lane1 valid=0 -> lane0 hs_byte 12,34 one cycle later; lane1 00; trail lane0 8'hFF x2, lane1 8'h00 x2 (from B8 bit 7=1).
REQ-031 txrequest_hs pulsed 1 cycle -> full prepare/zero/SYNC, then TRAIL 2, EXIT 4, STOP; txready_hs never high.
REQ-032 reset asserted in HS -> all outputs at reset values same cycle, no TRAIL bytes.
REQ-033 DPHY_ULPS_EN: ulps_req high 10 cycles -> lane_lp 10,00..., ulps_active=1; release -> 10 x4, then 11, stopstate=1; without macro lane_lp stays 11.
REQ-034 txrequest_hs and ulps_req high together in STOP -> HS_RQST (lane_lp 01), ulps_active stays 0.
